dmem_access: RTL and testbench
==============================

DMEM_ACCESS -- requirements
Module: dmem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, bus wait cycles before abort (used only with DMEM_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports ALUResultM, WriteDataM, PCplus4M  in  32 each  M-stage address/ALU result, store data, return address.
REQ-005 SHALL have port RdM  in  5  destination register.
REQ-006 SHALL have ports ValidM, RegWriteM, MemReadM, MemWriteM  in  1 each  M-stage valid and controls.
REQ-007 SHALL have port Funct3M  in  3  access size/sign; port ResultSrcM  in  2  (00 ALU, 01 load data, 10 PCplus4, 11 ALU).
REQ-008 SHALL have port StallM  out  1  holds the upstream pipeline while an access is outstanding.
REQ-009 SHALL have ports bus_req, bus_we  out  1; bus_addr, bus_wdata  out  32; bus_wstrb  out  4; bus_ack  in  1; bus_rdata  in  32.
REQ-010 SHALL have ports ResultW  out  32; RdW  out  5; RegWriteW, ValidW, MisalignW, BusErrW  out  1 each (MEM/WB register).

Function
REQ-011 SHALL implement FSM states IDLE and WAIT; memop = ValidM & (MemReadM | MemWriteM).
REQ-012 SHALL flag misaligned: Funct3M[1:0]=01 with addr[0]=1, or Funct3M[1:0]=10 with addr[1:0]!=00.
REQ-013 IDLE with memop & aligned: StallM=1 combinationally, next state WAIT; bus_addr/bus_we/bus_wdata/bus_wstrb registered on that edge.
REQ-014 WAIT: bus_req=1 and bus outputs held stable; StallM = ~bus_ack; on bus_ack=1 next state IDLE.
REQ-015 SHALL ignore bus_ack and bus_rdata in IDLE; bus_rdata sampled only in WAIT with bus_ack=1.
REQ-016 Minimum memory access latency SHALL be 2 cycles in M (one stall cycle) when bus_ack is returned in the first WAIT cycle.
REQ-017 Non-memory valid instructions SHALL pass to W in one cycle with StallM=0.
REQ-018 Each edge with StallM=1 SHALL load a bubble into W: ValidW=0, RegWriteW=0, MisalignW=0, BusErrW=0.
REQ-019 Each edge with StallM=0 SHALL load W from M: RdW=RdM, ValidW=ValidM, RegWriteW=RegWriteM&ValidM&~MisalignFlag, ResultW per ResultSrcM.
REQ-020 Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW passes; byte/half lane selected by registered bus_addr[1:0].
REQ-021 Stores: bus_wstrb=0001<<a[1:0] (SB), 0011<<a[1:0] (SH), 1111 (SW); bus_wdata replicates byte/halfword across lanes.
REQ-022 bus_addr SHALL be word-aligned (addr[1:0] forced to 00); bus_we=1 for stores, 0 for loads.
REQ-023 Misaligned memop SHALL make no bus request, no stall; W gets MisalignW=1, RegWriteW=0 for exactly one cycle.
REQ-024 Store completion SHALL write W with RegWriteW=0 unless RegWriteM=1.

Reset
REQ-025 On reset=1 at an edge: state IDLE, bus_req=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, all W outputs 0.
REQ-026 Reset during WAIT SHALL abandon the access; bus_req low from the following cycle; a later bus_ack SHALL be ignored.
REQ-027 StallM SHALL be 0 while reset=1.

Configuration
REQ-028 With DMEM_TIMEOUT_EN defined: a counter SHALL count WAIT cycles without bus_ack; after TIMEOUT_CYCLES cycles FSM returns IDLE, StallM released, W gets BusErrW=1, RegWriteW=0.
REQ-029 bus_ack arriving in the same cycle the count expires SHALL take priority (normal completion, BusErrW=0).
REQ-030 Without DMEM_TIMEOUT_EN: no counter; WAIT persists until bus_ack; BusErrW tied 0.

Verification
REQ-031 ALU op ResultSrcM=00, ALUResultM=0x0000_1234, RdM=5 -> next cycle ResultW=0x0000_1234, RdW=5, StallM never high.
REQ-032 LB at 0x0000_0103, ack 1st WAIT cycle with rdata=0x80FF_0000 -> StallM high 1 cycle, ResultW=0xFFFF_FF80.
REQ-033 SH at 0x0000_0202, WriteDataM=0x0000_ABCD, ack after 3 WAIT cycles -> bus_wstrb=1100, bus_wdata=0xABCD_ABCD, bus_addr=0x200, StallM high 3 cycles.
REQ-034 LW at 0x0000_0006 -> no bus_req, MisalignW=1 one cycle, RegWriteW=0.
REQ-035 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> abort after 16 WAIT cycles, BusErrW=1, StallM released.
REQ-036 reset asserted in 2nd WAIT cycle, ack next cycle -> bus_req=0, all W outputs 0, ack ignored.

Source files
------------

// File: rtl/dmem_access_if.sv
// rtl/dmem_access_if.sv - data memory bus between the M-stage access unit and memory
interface dmem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_wstrb,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_wstrb,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/dmem_access.sv
// rtl/dmem_access.sv - M-stage data memory access unit with MEM/WB register; DMEM_TIMEOUT_EN adds a bus timeout
module dmem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   ALUResultM,
    input  logic [31:0]   WriteDataM,
    input  logic [31:0]   PCplus4M,
    input  logic [4:0]    RdM,
    input  logic          ValidM,
    input  logic          RegWriteM,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [2:0]    Funct3M,
    input  logic [1:0]    ResultSrcM,
    output logic          StallM,
    dmem_access_if.master bus,
    output logic [31:0]   ResultW,
    output logic [4:0]    RdW,
    output logic          RegWriteW,
    output logic          ValidW,
    output logic          MisalignW,
    output logic          BusErrW
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic        memop;
    logic        misaligned;
    logic        misalign_flag;
    logic        start;
    logic        timeout_hit;

    logic        launch;
    logic        complete;
    logic        abort;
    logic        req;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;

    logic [31:0] store_wdata;
    logic [3:0]  store_wstrb;
    logic [31:0] lane_data;
    logic [31:0] load_data;
    logic [31:0] result_m;

    assign memop         = ValidM & (MemReadM | MemWriteM);
    assign misaligned    = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                           ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
    assign misalign_flag = memop & misaligned;
    assign start         = memop & ~misaligned;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count consecutive WAIT cycles that have not been acknowledged
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT) && !bus.bus_ack && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // The last permitted WAIT cycle without an ack aborts; an ack in that cycle still wins
    assign timeout_hit = (state == S_WAIT) & ~bus.bus_ack &
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE launches aligned accesses, WAIT ends on ack or timeout
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_WAIT;
            S_WAIT:  if (bus.bus_ack || timeout_hit) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: stall while an access is pending, ack/rdata only matter in WAIT
    always_comb begin
        launch   = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        req      = 1'b0;
        StallM   = 1'b0;
        case (state)
            S_IDLE: begin
                launch = start;
                StallM = start;
            end
            S_WAIT: begin
                req      = 1'b1;
                complete = bus.bus_ack;
                abort    = timeout_hit;
                StallM   = ~(bus.bus_ack | timeout_hit);
            end
            default: ;
        endcase
        if (reset) begin
            launch   = 1'b0;
            complete = 1'b0;
            abort    = 1'b0;
            StallM   = 1'b0;
        end
    end

    // Store lane formatting: replicate narrow data across lanes, strobe picks the lane
    always_comb begin
        store_wdata = WriteDataM;
        store_wstrb = 4'b1111;
        case (Funct3M[1:0])
            2'b00: begin
                store_wdata = {4{WriteDataM[7:0]}};
                store_wstrb = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                store_wdata = {2{WriteDataM[15:0]}};
                store_wstrb = 4'b0011 << ALUResultM[1:0];
            end
            default: ;
        endcase
        if (!MemWriteM) begin
            store_wstrb = 4'b0000;
        end
    end

    // Bus request fields are captured at launch and held for the whole WAIT period
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wstrb_q  <= '0;
            funct3_q <= '0;
            lane_q   <= '0;
        end else if (launch) begin
            addr_q   <= {ALUResultM[31:2], 2'b00};
            wdata_q  <= store_wdata;
            we_q     <= MemWriteM;
            wstrb_q  <= store_wstrb;
            funct3_q <= Funct3M;
            lane_q   <= ALUResultM[1:0];
        end
    end

    assign bus.bus_req   = req;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wstrb = wstrb_q;

    // Load extraction: shift the addressed lane down, then sign- or zero-extend
    always_comb begin
        lane_data = bus.bus_rdata >> {lane_q, 3'b000};
        load_data = lane_data;
        case (funct3_q)
            3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_data = {24'h000000, lane_data[7:0]};
            3'b101:  load_data = {16'h0000, lane_data[15:0]};
            default: load_data = lane_data;
        endcase
    end

    // Writeback source select; load data is only taken on the acknowledged cycle
    always_comb begin
        result_m = ALUResultM;
        case (ResultSrcM)
            2'b01:   result_m = complete ? load_data : 32'h0000_0000;
            2'b10:   result_m = PCplus4M;
            default: result_m = ALUResultM;
        endcase
    end

    // MEM/WB register: bubble while stalled, otherwise take the M-stage instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            ResultW   <= '0;
            RdW       <= '0;
            RegWriteW <= 1'b0;
            ValidW    <= 1'b0;
            MisalignW <= 1'b0;
            BusErrW   <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            ValidW    <= 1'b0;
            MisalignW <= 1'b0;
            BusErrW   <= 1'b0;
        end else begin
            ResultW   <= result_m;
            RdW       <= RdM;
            RegWriteW <= RegWriteM & ValidM & ~misalign_flag & ~abort;
            ValidW    <= ValidM;
            MisalignW <= misalign_flag;
            BusErrW   <= abort;
        end
    end

endmodule

// File: tb/tb_dmem_access.sv
// tb/tb_dmem_access.sv - self-checking bench for dmem_access
module tb_dmem_access;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultM, WriteDataM, PCplus4M;
    logic [4:0]  RdM;
    logic        ValidM, RegWriteM, MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [1:0]  ResultSrcM;
    logic        StallM;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW, ValidW, MisalignW, BusErrW;

    dmem_access_if bus();

    dmem_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCplus4M   (PCplus4M),
        .RdM        (RdM),
        .ValidM     (ValidM),
        .RegWriteM  (RegWriteM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ResultSrcM (ResultSrcM),
        .StallM     (StallM),
        .bus        (bus),
        .ResultW    (ResultW),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .ValidW     (ValidW),
        .MisalignW  (MisalignW),
        .BusErrW    (BusErrW)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // what the driver says the current cycle is
    logic cur_stall, cur_in_wait, cur_complete, cur_abort;
    int   stall_seen, req_seen;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_we;

    logic        have_exp = 1'b0;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    logic        e_valid, e_rw, e_mis, e_berr, e_rd_chk, e_res_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return ((f3[1:0] == 2'b01) && (a % 2 != 0)) || ((f3[1:0] == 2'b10) && (a % 4 != 0));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [7:0]  by [4];
        logic [7:0]  b;
        logic [15:0] h;
        int l;
        for (int i = 0; i < 4; i++) by[i] = rdata[8*i +: 8];
        l = int'(a % 4);
        b = by[l];
        h = {by[(l + 1) % 4], by[l]};
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s;
        int l;
        s = 4'h0;
        l = int'(a % 4);
        case (f3[1:0])
            2'b00:   s[l] = 1'b1;
            2'b01:   begin s[l] = 1'b1; s[(l + 1) % 4] = 1'b1; end
            default: s = 4'hF;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            2'b01:   return {wd[15:0], wd[15:0]};
            default: return wd;
        endcase
    endfunction

    // single compare process: W register, StallM and bus outputs every cycle
    always @(negedge clk) begin
        logic mis;
        if (have_exp) begin
            chk("valid_w", ValidW, e_valid);
            chk("regwrite_w", RegWriteW, e_rw);
            chk("misalign_w", MisalignW, e_mis);
            chk("buserr_w", BusErrW, e_berr);
            if (e_rd_chk)  chk("rd_w", RdW, e_rd);
            if (e_res_chk) chk("result_w", ResultW, e_res);
        end
        if (reset) begin
            chk("stall_in_reset", StallM, 1'b0);
        end else begin
            chk("stall_m", StallM, cur_stall);
            chk("bus_req", bus.bus_req, cur_in_wait);
        end
        if (StallM) stall_seen++;
        if (bus.bus_req) begin
            req_seen++;
            last_addr  = bus.bus_addr;
            last_wdata = bus.bus_wdata;
            last_wstrb = bus.bus_wstrb;
            last_we    = bus.bus_we;
        end
        if (!reset && cur_in_wait) begin
            chk("bus_addr", bus.bus_addr, ALUResultM - (ALUResultM % 4));
            chk("bus_we", bus.bus_we, MemWriteM);
            if (MemWriteM) begin
                chk("bus_wstrb", bus.bus_wstrb, model_strb(Funct3M, ALUResultM));
                chk("bus_wdata", bus.bus_wdata, model_wdata(Funct3M, WriteDataM));
            end else begin
                chk("bus_wstrb_load", bus.bus_wstrb, 4'h0);
            end
        end
        have_exp = 1'b1;
        if (reset) begin
            {e_valid, e_rw, e_mis, e_berr} = 4'b0;
            e_rd = 5'd0; e_res = 32'd0; e_rd_chk = 1'b1; e_res_chk = 1'b1;
        end else if (cur_stall) begin
            {e_valid, e_rw, e_mis, e_berr} = 4'b0;
            e_rd_chk = 1'b0; e_res_chk = 1'b0;
        end else begin
            mis       = ValidM && (MemReadM || MemWriteM) && model_misaligned(Funct3M, ALUResultM);
            e_valid   = ValidM;
            e_rw      = RegWriteM && ValidM && !mis && !cur_abort;
            e_mis     = mis;
            e_berr    = cur_abort;
            e_rd      = RdM;
            e_rd_chk  = 1'b1;
            case (ResultSrcM)
                2'b01: begin
                    e_res     = model_load(Funct3M, ALUResultM, bus.bus_rdata);
                    e_res_chk = cur_complete && MemReadM;
                end
                2'b10: begin
                    e_res     = PCplus4M;
                    e_res_chk = ValidM && !mis && !cur_abort;
                end
                default: begin
                    e_res     = ALUResultM;
                    e_res_chk = ValidM && !mis && !cur_abort;
                end
            endcase
        end
    end

    task automatic set_m(input logic v, rw, mr, mw, input logic [2:0] f3, input logic [1:0] src,
                         input logic [31:0] alu, wd, pc4, input logic [4:0] rd);
        ValidM = v; RegWriteM = rw; MemReadM = mr; MemWriteM = mw;
        Funct3M = f3; ResultSrcM = src; ALUResultM = alu; WriteDataM = wd;
        PCplus4M = pc4; RdM = rd;
    endtask

    task automatic idle_inputs();
        set_m(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
        cur_stall = 1'b0; cur_in_wait = 1'b0; cur_complete = 1'b0; cur_abort = 1'b0;
    endtask

    // one instruction in M; ack_at = WAIT cycle carrying the ack (0 = never)
    task automatic issue(input logic rw, mr, mw, input logic [2:0] f3, input logic [1:0] src,
                         input logic [31:0] alu, wd, pc4, input logic [4:0] rd,
                         input int ack_at, input logic [31:0] rdata);
        logic aligned, timed_out;
        int n_wait;
        aligned   = (mr || mw) && !model_misaligned(f3, alu);
        timed_out = 1'b0;
        n_wait    = 0;
        if (aligned) begin
            n_wait = ack_at;
`ifdef DMEM_TIMEOUT_EN
            if (ack_at == 0 || ack_at > T) begin
                n_wait = T;
                timed_out = 1'b1;
            end
`endif
        end
        stall_seen = 0;
        req_seen   = 0;
        set_m(1'b1, rw, mr, mw, f3, src, alu, wd, pc4, rd);
        for (int k = 0; k <= n_wait; k++) begin
            bus.bus_ack   = (k == 0) ? 1'b1 : (k == ack_at);
            bus.bus_rdata = (k == 0) ? 32'hDEAD_BEEF : ((k == ack_at) ? rdata : ~rdata);
            cur_stall     = aligned && (k < n_wait);
            cur_in_wait   = (k >= 1);
            cur_complete  = (k >= 1) && (k == n_wait) && !timed_out;
            cur_abort     = timed_out && (k == n_wait);
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        stall_seen = 0; req_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_req", bus.bus_req, 1'b0);
        chk("rst_bus_we", bus.bus_we, 1'b0);
        chk("rst_bus_wstrb", bus.bus_wstrb, 4'h0);
        chk("rst_bus_addr", bus.bus_addr, 32'h0);
        chk("rst_bus_wdata", bus.bus_wdata, 32'h0);
        chk("rst_result_w", ResultW, 32'h0);
        chk("rst_valid_w", ValidW, 1'b0);
        chk("rst_stall", StallM, 1'b0);
        reset = 1'b0;
        next_cycle();

        // ALU op
        issue(1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0000_1234, 32'h0, 32'h100, 5'd5, 0, 32'h0);
        @(negedge clk);
        chk("alu_result", ResultW, 32'h0000_1234);
        chk("alu_rd", RdW, 5'd5);
        chk("alu_stall_cycles", stall_seen, 0);
        next_cycle();

        // JAL-style writeback of PC+4
        issue(1'b1, 1'b0, 1'b0, 3'b000, 2'b10, 32'h0000_0999, 32'h0, 32'h0000_0044, 5'd1, 0, 32'h0);
        @(negedge clk);
        chk("pc4_result", ResultW, 32'h0000_0044);
        next_cycle();

        // LB at 0x103, ack in first WAIT cycle
        issue(1'b1, 1'b1, 1'b0, 3'b000, 2'b01, 32'h0000_0103, 32'h0, 32'h0, 5'd9, 1, 32'h80FF_0000);
        @(negedge clk);
        chk("lb_result", ResultW, 32'hFFFF_FF80);
        chk("lb_stall_cycles", stall_seen, 1);
        chk("lb_regwrite", RegWriteW, 1'b1);
        next_cycle();

        issue(1'b1, 1'b1, 1'b0, 3'b100, 2'b01, 32'h0000_0101, 32'h0, 32'h0, 5'd10, 2, 32'h1234_5678);
        @(negedge clk);
        chk("lbu_result", ResultW, 32'h0000_0056);
        next_cycle();

        issue(1'b1, 1'b1, 1'b0, 3'b001, 2'b01, 32'h0000_0102, 32'h0, 32'h0, 5'd11, 1, 32'h8001_0000);
        @(negedge clk);
        chk("lh_result", ResultW, 32'hFFFF_8001);
        next_cycle();

        issue(1'b1, 1'b1, 1'b0, 3'b101, 2'b01, 32'h0000_0000, 32'h0, 32'h0, 5'd12, 1, 32'h0000_F00D);
        @(negedge clk);
        chk("lhu_result", ResultW, 32'h0000_F00D);
        next_cycle();

        issue(1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h0000_0040, 32'h0, 32'h0, 5'd13, 2, 32'hCAFE_BABE);
        @(negedge clk);
        chk("lw_result", ResultW, 32'hCAFE_BABE);
        chk("lw_stall_cycles", stall_seen, 2);
        next_cycle();

        // SH at 0x202, ack in third WAIT cycle
        issue(1'b0, 1'b0, 1'b1, 3'b001, 2'b00, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 5'd0, 3, 32'h0);
        @(negedge clk);
        chk("sh_wstrb", last_wstrb, 4'b1100);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_addr", last_addr, 32'h0000_0200);
        chk("sh_we", last_we, 1'b1);
        chk("sh_stall_cycles", stall_seen, 3);
        chk("sh_regwrite", RegWriteW, 1'b0);
        next_cycle();

        issue(1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_0001, 32'h0000_0077, 32'h0, 5'd0, 1, 32'h0);
        @(negedge clk);
        chk("sb_wstrb", last_wstrb, 4'b0010);
        chk("sb_wdata", last_wdata, 32'h7777_7777);
        next_cycle();

        // store with RegWriteM set keeps its register write
        issue(1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 32'h0000_0010, 32'h1357_9BDF, 32'h0, 5'd3, 2, 32'h0);
        @(negedge clk);
        chk("sw_wstrb", last_wstrb, 4'b1111);
        chk("sw_regwrite", RegWriteW, 1'b1);
        next_cycle();

        // misaligned LW at 0x6
        issue(1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h0000_0006, 32'h0, 32'h0, 5'd4, 1, 32'h0);
        @(negedge clk);
        chk("mis_req_cycles", req_seen, 0);
        chk("mis_stall_cycles", stall_seen, 0);
        chk("mis_flag", MisalignW, 1'b1);
        chk("mis_regwrite", RegWriteW, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("mis_one_cycle", MisalignW, 1'b0);
        next_cycle();

        issue(1'b1, 1'b0, 1'b1, 3'b001, 2'b00, 32'h0000_0003, 32'h55, 32'h0, 5'd0, 1, 32'h0);
        @(negedge clk);
        chk("mis_sh_flag", MisalignW, 1'b1);
        chk("mis_sh_req_cycles", req_seen, 0);
        next_cycle();

`ifdef DMEM_TIMEOUT_EN
        issue(1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h0000_0080, 32'h0, 32'h0, 5'd6, 0, 32'h0);
        @(negedge clk);
        chk("to_stall_cycles", stall_seen, T);
        chk("to_req_cycles", req_seen, T);
        chk("to_buserr", BusErrW, 1'b1);
        chk("to_regwrite", RegWriteW, 1'b0);
        chk("to_stall_released", StallM, 1'b0);
        next_cycle();

        issue(1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h0000_0084, 32'h0, 32'h0, 5'd7, T, 32'h0BAD_F00D);
        @(negedge clk);
        chk("ack_at_limit_buserr", BusErrW, 1'b0);
        chk("ack_at_limit_result", ResultW, 32'h0BAD_F00D);
        next_cycle();
`else
        issue(1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h0000_0080, 32'h0, 32'h0, 5'd6, 20, 32'h0BAD_F00D);
        @(negedge clk);
        chk("slow_stall_cycles", stall_seen, 20);
        chk("slow_buserr", BusErrW, 1'b0);
        chk("slow_result", ResultW, 32'h0BAD_F00D);
        next_cycle();
`endif

        // reset in the second WAIT cycle, ack arriving afterwards
        set_m(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h0000_0080, 32'h0, 32'h84, 5'd7);
        cur_stall = 1'b1;
        next_cycle();
        cur_in_wait = 1'b1;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wait_stall", StallM, 1'b0);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        bus.bus_ack = 1'b1;
        bus.bus_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rst_wait_req", bus.bus_req, 1'b0);
        chk("rst_wait_valid_w", ValidW, 1'b0);
        chk("rst_wait_regwrite_w", RegWriteW, 1'b0);
        chk("rst_wait_result_w", ResultW, 32'h0);
        chk("rst_wait_rd_w", RdW, 5'd0);
        next_cycle();
        @(negedge clk);
        chk("late_ack_req", bus.bus_req, 1'b0);
        chk("late_ack_stall", StallM, 1'b0);
        next_cycle();
        bus.bus_ack = 1'b0;

        issue(1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0000_4321, 32'h0, 32'h0, 5'd2, 0, 32'h0);
        @(negedge clk);
        chk("post_rst_result", ResultW, 32'h0000_4321);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
